// File: rtl/bit_stream_gen.sv
`timescale 1ns/1ps
// bit_stream_gen: serial NRZ test-pattern source.
// After enable, it sends an alternating preamble and then a payload. The payload
// is PRBS7, a continued alternating pattern, or a repeated 16-bit word.
// Each bit lasts max(bit_period, 2) clock cycles. That length is latched at
// every bit start. Alongside the data, the block provides a per-bit strobe and
// a half-bit reference clock.

module bit_stream_gen #(
    parameter int         PERIOD_W      = 16,
    parameter int         PREAMBLE_BITS = 16,
    parameter logic [6:0] PRBS_SEED     = 7'h7F
) (
    input  logic                clk_300M,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic [15:0]         pattern_word,
    output logic                signal,
    output logic                bit_strobe,
    output logic                clk_ref,
    output logic                busy
);

    localparam int                PRE_W      = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PREAMBLE_BITS - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE    = PRE_W'(1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] CNT_ONE    = PERIOD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PL_PRBS    = 2'd0,
        PL_ALT     = 2'd1,
        PL_PATTERN = 2'd2
    } payload_t;

    state_t              state;
    payload_t            payload_kind;
    logic [PERIOD_W-1:0] period_cnt;
    logic [PERIOD_W-1:0] period_len;
    logic [PRE_W-1:0]    pre_cnt;
    logic [3:0]          pat_idx;
    logic [15:0]         pat_word;
    logic [6:0]          lfsr;

    logic [PERIOD_W-1:0] period_next;
    logic [PERIOD_W-1:0] cnt_inc;
    logic                bit_end;
    logic                ref_next;
    payload_t            entry_kind;
    logic                entry_bit;
    logic [6:0]          lfsr_next;
    logic [3:0]          pat_idx_next;
    logic [15:0]         pat_word_next;
    logic                payload_bit;

    // Bit timing: effective period of the next bit, end-of-bit detect and next clk_ref level
    always_comb begin
        period_next = (bit_period < MIN_PERIOD) ? MIN_PERIOD : bit_period;
        cnt_inc     = period_cnt + CNT_ONE;
        bit_end     = (period_cnt == (period_len - CNT_ONE));
        ref_next    = (cnt_inc < (period_len >> 1));
    end

    // Payload selection at PAYLOAD entry and the next payload bit while already in PAYLOAD
    always_comb begin
        entry_kind    = PL_PRBS;
        entry_bit     = PRBS_SEED[6];
        lfsr_next     = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        pat_idx_next  = pat_idx - 4'd1;
        pat_word_next = (pat_idx == 4'd0) ? pattern_word : pat_word;
        payload_bit   = 1'b0;

        case (mode)
            2'b01: begin
                entry_kind = PL_ALT;
                entry_bit  = ~signal;
            end
            2'b10: begin
                entry_kind = PL_PATTERN;
                entry_bit  = pattern_word[15];
            end
            default: begin
                entry_kind = PL_PRBS;
                entry_bit  = PRBS_SEED[6];
            end
        endcase

        case (payload_kind)
            PL_PRBS:    payload_bit = lfsr_next[6];
            PL_ALT:     payload_bit = ~signal;
            PL_PATTERN: payload_bit = pat_word_next[pat_idx_next];
            default:    payload_bit = 1'b0;
        endcase
    end

    // Main FSM: all outputs are registered; a bit only ends after its full latched period
    always_ff @(posedge clk_300M) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            payload_kind <= PL_PRBS;
            period_cnt   <= '0;
            period_len   <= '0;
            pre_cnt      <= '0;
            pat_idx      <= '0;
            pat_word     <= '0;
            lfsr         <= PRBS_SEED;
            signal       <= 1'b0;
            bit_strobe   <= 1'b0;
            clk_ref      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    period_cnt <= '0;
                    pre_cnt    <= '0;
                    pat_idx    <= '0;
                    if (enable) begin
                        state      <= ST_PREAMBLE;
                        period_len <= period_next;
                        signal     <= 1'b1;
                        bit_strobe <= 1'b1;
                        clk_ref    <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        period_len <= '0;
                        signal     <= 1'b0;
                        bit_strobe <= 1'b0;
                        clk_ref    <= 1'b0;
                        busy       <= 1'b0;
                    end
                end

                ST_PREAMBLE, ST_PAYLOAD: begin
                    if (!bit_end) begin
                        period_cnt <= cnt_inc;
                        bit_strobe <= 1'b0;
                        clk_ref    <= ref_next;
                    end else if (!enable) begin
                        state      <= ST_IDLE;
                        period_cnt <= '0;
                        period_len <= '0;
                        pre_cnt    <= '0;
                        pat_idx    <= '0;
                        signal     <= 1'b0;
                        bit_strobe <= 1'b0;
                        clk_ref    <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        period_cnt <= '0;
                        period_len <= period_next;
                        bit_strobe <= 1'b1;
                        clk_ref    <= 1'b1;
                        if (state == ST_PREAMBLE) begin
                            if (pre_cnt == PRE_LAST) begin
                                state        <= ST_PAYLOAD;
                                pre_cnt      <= '0;
                                payload_kind <= entry_kind;
                                signal       <= entry_bit;
                                lfsr         <= PRBS_SEED;
                                pat_word     <= pattern_word;
                                pat_idx      <= 4'd15;
                            end else begin
                                pre_cnt <= pre_cnt + PRE_ONE;
                                signal  <= ~signal;
                            end
                        end else begin
                            signal <= payload_bit;
                            if (payload_kind == PL_PRBS) begin
                                lfsr <= lfsr_next;
                            end
                            if (payload_kind == PL_PATTERN) begin
                                pat_idx  <= pat_idx_next;
                                pat_word <= pat_word_next;
                            end
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    period_cnt <= '0;
                    period_len <= '0;
                    pre_cnt    <= '0;
                    pat_idx    <= '0;
                    signal     <= 1'b0;
                    bit_strobe <= 1'b0;
                    clk_ref    <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_stream_gen.sv
`timescale 1ns/1ps
// tb_bit_stream_gen: randomized and directed checks of bit_stream_gen.
// The reference model tracks the stream as a bit number and a cycle-in-bit.
// From those it derives each expected output level.

module tb_bit_stream_gen;

    localparam int         PERIOD_W = 16;
    localparam int         PRE      = 16;
    localparam logic [6:0] SEED     = 7'h7F;

    logic                clk_300M     = 1'b0;
    logic                rst_n        = 1'b0;
    logic                enable       = 1'b0;
    logic [1:0]          mode         = 2'b00;
    logic [PERIOD_W-1:0] bit_period   = '0;
    logic [15:0]         pattern_word = '0;
    logic                signal;
    logic                bit_strobe;
    logic                clk_ref;
    logic                busy;

    int n_compared = 0;
    int n_failed   = 0;

    bit_stream_gen #(
        .PERIOD_W      (PERIOD_W),
        .PREAMBLE_BITS (PRE),
        .PRBS_SEED     (SEED)
    ) dut (
        .clk_300M     (clk_300M),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .bit_period   (bit_period),
        .pattern_word (pattern_word),
        .signal       (signal),
        .bit_strobe   (bit_strobe),
        .clk_ref      (clk_ref),
        .busy         (busy)
    );

    // Free-running clock
    always #2 clk_300M = ~clk_300M;

    // Reference model state
    int          m_active = 0;
    int          m_bit    = 0;
    int          m_cyc    = 0;
    int          m_peff   = 2;
    int          m_mode   = 0;
    logic [15:0] m_word   = '0;
    logic        prbs_tab [127];
    logic [3:0]  exp_vec  = 4'b0000;

    function automatic int clamp_period(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic logic model_bit();
        int j;
        if (m_bit < PRE) return (m_bit % 2 == 0);
        j = m_bit - PRE;
        case (m_mode)
            1:       return (m_bit % 2 == 0);
            2:       return m_word[15 - (j % 16)];
            default: return prbs_tab[j % 127];
        endcase
    endfunction

    task automatic build_prbs_table();
        logic [6:0] v;
        v = SEED;
        for (int i = 0; i < 127; i++) begin
            prbs_tab[i] = v[6];
            v = {v[5:0], v[6] ^ v[5]};
        end
    endtask

    // Model advances on each rising edge from the inputs sampled there
    always @(posedge clk_300M) begin
        if (rst_n == 1'b0) begin
            m_active = 0;
        end else if (m_active == 0) begin
            if (enable) begin
                m_active = 1;
                m_bit    = 0;
                m_cyc    = 0;
                m_peff   = clamp_period(int'(bit_period));
            end
        end else if (m_cyc < m_peff - 1) begin
            m_cyc++;
        end else if (!enable) begin
            m_active = 0;
        end else begin
            m_bit++;
            m_cyc  = 0;
            m_peff = clamp_period(int'(bit_period));
            if (m_bit == PRE) m_mode = int'(mode);
            if (m_bit >= PRE && m_mode == 2 && ((m_bit - PRE) % 16) == 0) m_word = pattern_word;
        end
        if (m_active != 0)
            exp_vec = {model_bit(), (m_cyc == 0), (m_cyc < m_peff / 2), 1'b1};
        else
            exp_vec = 4'b0000;
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk_300M);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; mode = 2'b01; bit_period = 16'd4;
        repeat (3) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== 4'b0000) begin
                n_failed++;
                $display("[TB] FAIL reset_outputs got=%b want=0000", {signal, bit_strobe, clk_ref, busy});
            end
        end
        rst_n = 1'b1;
        @(negedge clk_300M);
        n_compared++;
        if ({signal, bit_strobe, clk_ref, busy} !== 4'b1111) begin
            n_failed++;
            $display("[TB] FAIL first_bit_start got=%b want=1111", {signal, bit_strobe, clk_ref, busy});
        end
    endtask

    task automatic test_alternating();
        int   strobes;
        int   highs;
        logic bits[$];
        do_reset();
        mode = 2'b01; bit_period = 16'd6; enable = 1'b1;
        strobes = 0; highs = 0;
        for (int c = 0; c < 156; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL alt_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
            if (bit_strobe) begin strobes++; bits.push_back(signal); end
            if (clk_ref) highs++;
        end
        n_compared++;
        if (strobes != 26) begin n_failed++; $display("[TB] FAIL alt_strobes got=%0d want=26", strobes); end
        n_compared++;
        if (highs != 78) begin n_failed++; $display("[TB] FAIL alt_ref_high got=%0d want=78", highs); end
        for (int k = 0; k < bits.size(); k++) begin
            n_compared++;
            if (bits[k] !== logic'(k % 2 == 0)) begin
                n_failed++;
                $display("[TB] FAIL alt_polarity bit=%0d got=%b want=%b", k, bits[k], (k % 2 == 0));
            end
        end
    endtask

    task automatic test_min_period();
        int strobes;
        int highs;
        int found;
        do_reset();
        mode = 2'b01; bit_period = 16'd0; enable = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            strobes = 0; highs = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk_300M);
                n_compared++;
                if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                    n_failed++;
                    $display("[TB] FAIL minp_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
                end
                if (bit_strobe) strobes++;
                if (clk_ref) highs++;
            end
            n_compared++;
            if (strobes != 10 || highs != 10) begin
                n_failed++;
                $display("[TB] FAIL minp_rate phase=%0d got=%0d/%0d want=10/10", phase, strobes, highs);
            end
            bit_period = 16'd1;
        end
        bit_period = 16'd7;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk_300M);
            if (bit_strobe) found = 1;
        end
        n_compared++;
        if (found == 0) begin
            n_failed++;
            $display("[TB] FAIL odd_period_wait got=no_strobe want=strobe");
        end else begin
            highs = clk_ref ? 1 : 0;
            for (int c = 1; c < 7; c++) begin
                @(negedge clk_300M);
                if (clk_ref) highs++;
            end
            n_compared++;
            if (highs != 3) begin n_failed++; $display("[TB] FAIL odd_ref_high got=%0d want=3", highs); end
            @(negedge clk_300M);
            n_compared++;
            if (bit_strobe !== 1'b1) begin n_failed++; $display("[TB] FAIL odd_bit_len got=%b want=1", bit_strobe); end
        end
    endtask

    task automatic test_prbs();
        logic       bits[$];
        logic [7:0] head;
        head = 8'b1111_1110;
        do_reset();
        mode = 2'b00; bit_period = 16'd4; enable = 1'b1;
        for (int c = 0; c < 608; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL prbs_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
            if (bit_strobe) bits.push_back(signal);
        end
        n_compared++;
        if (bits.size() < 151) begin
            n_failed++;
            $display("[TB] FAIL prbs_bitcount got=%0d want>=151", bits.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_compared += 2;
                if (bits[PRE + i] !== head[7 - i]) begin
                    n_failed++;
                    $display("[TB] FAIL prbs_head i=%0d got=%b want=%b", i, bits[PRE + i], head[7 - i]);
                end
                if (bits[PRE + 127 + i] !== head[7 - i]) begin
                    n_failed++;
                    $display("[TB] FAIL prbs_repeat i=%0d got=%b want=%b", i, bits[PRE + 127 + i], head[7 - i]);
                end
            end
        end
    endtask

    task automatic test_pattern();
        logic        bits[$];
        logic [15:0] w;
        logic [15:0] want [3];
        want[0] = 16'hA5F0; want[1] = 16'hA5F0; want[2] = 16'h3C3C;
        do_reset();
        mode = 2'b10; pattern_word = 16'hA5F0; bit_period = 16'd3; enable = 1'b1;
        for (int c = 0; c < 192; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL pat_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
            if (bit_strobe) bits.push_back(signal);
            if (c == 107) pattern_word = 16'h3C3C;
        end
        n_compared++;
        if (bits.size() != 64) begin
            n_failed++;
            $display("[TB] FAIL pat_bitcount got=%0d want=64", bits.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                w = '0;
                for (int i = 0; i < 16; i++) w = {w[14:0], bits[PRE + 16 * k + i]};
                n_compared++;
                if (w !== want[k]) begin
                    n_failed++;
                    $display("[TB] FAIL pat_word k=%0d got=%h want=%h", k, w, want[k]);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        int busy_cnt;
        int low_cnt;
        int strobes;
        do_reset();
        mode = 2'b01; bit_period = 16'd10; enable = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL drop_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
        end
        enable = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL drop_tail t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
            if (busy) busy_cnt++;
        end
        n_compared++;
        if (busy_cnt != 6) begin n_failed++; $display("[TB] FAIL drop_tail_len got=%0d want=6", busy_cnt); end
        n_compared++;
        if ({signal, busy} !== 2'b00) begin n_failed++; $display("[TB] FAIL drop_idle got=%b want=00", {signal, busy}); end

        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 24; c++) @(negedge clk_300M);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) @(negedge clk_300M);
        enable = 1'b1;
        low_cnt = 0; strobes = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL reenable_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
            if (!busy) low_cnt++;
            if (bit_strobe) strobes++;
        end
        n_compared++;
        if (low_cnt != 0 || strobes != 3) begin
            n_failed++;
            $display("[TB] FAIL reenable_gap got=%0d/%0d want=0/3", low_cnt, strobes);
        end
    endtask

    task automatic test_reset_mid();
        int idx[$];
        do_reset();
        mode = 2'b00; bit_period = 16'd5; enable = 1'b1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL midrst_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
        end
        rst_n = 1'b0;
        @(negedge clk_300M);
        n_compared++;
        if ({signal, bit_strobe, clk_ref, busy} !== 4'b0000) begin
            n_failed++;
            $display("[TB] FAIL midrst_outputs got=%b want=0000", {signal, bit_strobe, clk_ref, busy});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_300M);
            if (bit_strobe) idx.push_back(c);
            if (c == 2) bit_period = 16'd9;
        end
        n_compared++;
        if (idx.size() < 3) begin
            n_failed++;
            $display("[TB] FAIL period_change got=%0d strobes want>=3", idx.size());
        end else if (idx[0] != 0 || idx[1] != 5 || idx[2] != 14) begin
            n_failed++;
            $display("[TB] FAIL period_change got=%0d,%0d,%0d want=0,5,14", idx[0], idx[1], idx[2]);
        end
    endtask

    task automatic test_random();
        do_reset();
        enable = 1'b1; mode = 2'($urandom_range(0, 3)); bit_period = 16'($urandom_range(0, 9));
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_300M);
            n_compared++;
            if ({signal, bit_strobe, clk_ref, busy} !== exp_vec) begin
                n_failed++;
                $display("[TB] FAIL random_stream t=%0t got=%b want=%b", $time, {signal, bit_strobe, clk_ref, busy}, exp_vec);
            end
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) bit_period = 16'($urandom_range(0, 9));
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) pattern_word = 16'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
        end
    endtask

    // Test sequence
    initial begin
        build_prbs_table();
        test_reset();
        test_alternating();
        test_min_period();
        test_prbs();
        test_pattern();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
